// File: rtl/pb_prog_dr.sv
// JTAG data-register bank for program load / readback.
// Frame-length checked updates drive the instruction-memory write port.
module pb_prog_dr #(
  parameter int              ADDR_W     = 64,
  parameter int              DATA_W     = 32,
  parameter int              ADDR_STEP  = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [31:0]     IDCODE     = 32'h1BEEF001
) (
  input  logic              tck_i,
  input  logic              trst,
  input  logic              captureDR_i,
  input  logic              shiftDR_i,
  input  logic              updateDR_i,
  input  logic              tdi_i,
  input  logic [3:0]        irInstr_i,
  input  logic [DATA_W-1:0] rdData_i,
  output logic              tdo_o,
  output logic              wEn_o,
  output logic              rdEn_o,
  output logic [ADDR_W-1:0] loadAddr_o,
  output logic [DATA_W-1:0] loadData_o,
  output logic              frameErr_o
);

  localparam int CW = ADDR_W + DATA_W;
  localparam int LW = $clog2(CW + 2);
  localparam int IW = $clog2(CW);

  localparam logic [3:0] I_PROG  = 4'b0001;
  localparam logic [3:0] I_BURST = 4'b0100;
  localparam logic [3:0] I_READ  = 4'b0101;
  localparam logic [3:0] I_IDC   = 4'b0110;

  logic [CW-1:0]     chain_q, chain_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              wen_q, wen_d;
  logic              rden_q, rden_d;

  logic [LW-1:0]     len;
  logic [LW-1:0]     sat;
  logic [IW-1:0]     len_m1;
  logic [CW-1:0]     mask;

  always_comb begin
    len = LW'(1);
    unique case (irInstr_i)
      I_PROG:  len = LW'(CW);
      I_BURST: len = LW'(DATA_W);
      I_READ:  len = LW'(DATA_W);
      I_IDC:   len = LW'(32);
      default: len = LW'(1);
    endcase
  end

  // Only the low len bits of the chain take part in a shift.
  always_comb begin
    sat    = len + LW'(1);
    len_m1 = IW'(len - LW'(1));
    mask   = ~({CW{1'b1}} << len);
  end

  always_comb begin
    chain_d = chain_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    wen_d   = 1'b0;
    rden_d  = 1'b0;
    if (captureDR_i) begin
      cnt_d   = '0;
      chain_d = '0;
      if (irInstr_i == I_READ) begin
        chain_d[DATA_W-1:0] = rdData_i;
      end else if (irInstr_i == I_IDC) begin
        chain_d[31:0] = IDCODE;
      end
    end else if (shiftDR_i) begin
      chain_d = (chain_q & ~mask) | ((chain_q >> 1) & mask);
      chain_d[len_m1] = tdi_i;
      cnt_d = (cnt_q >= sat) ? sat : cnt_q + LW'(1);
    end else if (updateDR_i) begin
      cnt_d = '0;
      if (cnt_q != len) begin
        err_d = 1'b1;
      end else begin
        case (irInstr_i)
          I_PROG: begin
            addr_d = chain_q[ADDR_W-1:0];
            data_d = chain_q[CW-1:ADDR_W];
            wen_d  = 1'b1;
          end
          I_BURST: begin
            addr_d = addr_q + ADDR_W'(ADDR_STEP);
            data_d = chain_q[DATA_W-1:0];
            wen_d  = 1'b1;
          end
          I_READ: begin
            addr_d = addr_q + ADDR_W'(ADDR_STEP);
            rden_d = 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge tck_i or negedge trst) begin
    if (!trst) begin
      chain_q <= '0;
      cnt_q   <= '0;
      addr_q  <= RESET_ADDR;
      data_q  <= '0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
      rden_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      wen_q   <= wen_d;
      rden_q  <= rden_d;
    end
  end

  assign tdo_o      = chain_q[0];
  assign wEn_o      = wen_q;
  assign rdEn_o     = rden_q;
  assign loadAddr_o = addr_q;
  assign loadData_o = data_q;
  assign frameErr_o = err_q;

endmodule

// File: tb/tb_pb_prog_dr.sv
// Bench for pb_prog_dr: queue-based chain model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_pb_prog_dr;

  localparam logic [3:0] I_PROG  = 4'b0001;
  localparam logic [3:0] I_BYP   = 4'b0011;
  localparam logic [3:0] I_BURST = 4'b0100;
  localparam logic [3:0] I_READ  = 4'b0101;
  localparam logic [3:0] I_IDC   = 4'b0110;

  logic        tck_i = 1'b0;
  logic        trst;
  logic        captureDR_i, shiftDR_i, updateDR_i, tdi_i;
  logic [3:0]  irInstr_i;
  logic [31:0] rdData_i;
  logic        tdo_o, wEn_o, rdEn_o, frameErr_o;
  logic [63:0] loadAddr_o;
  logic [31:0] loadData_o;

  pb_prog_dr dut (
    .tck_i(tck_i), .trst(trst),
    .captureDR_i(captureDR_i), .shiftDR_i(shiftDR_i),
    .updateDR_i(updateDR_i), .tdi_i(tdi_i),
    .irInstr_i(irInstr_i), .rdData_i(rdData_i),
    .tdo_o(tdo_o), .wEn_o(wEn_o), .rdEn_o(rdEn_o),
    .loadAddr_o(loadAddr_o), .loadData_o(loadData_o),
    .frameErr_o(frameErr_o)
  );

  initial forever #5 tck_i = ~tck_i;

  int n_chk = 0;
  int n_fail = 0;
  int wen_seen = 0;
  int rden_seen = 0;

  logic [63:0] e_addr;
  logic [31:0] e_data;
  logic        e_err, e_wen, e_rden, e_tdo;
  int          e_cnt;
  logic        q[$];

  logic [95:0] tdo_bits;
  int          nsh;

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int len_of(input logic [3:0] ir);
    case (ir)
      I_PROG:  return 96;
      I_BURST: return 32;
      I_READ:  return 32;
      I_IDC:   return 32;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    e_addr = '0;
    e_data = '0;
    e_err  = 1'b0;
    e_wen  = 1'b0;
    e_rden = 1'b0;
    e_cnt  = 0;
    q.delete();
    q.push_back(1'b0);
    e_tdo  = 1'b0;
  endtask

  task automatic model_edge(input logic c, input logic s,
                            input logic u, input logic t);
    logic [95:0] v;
    int L;
    L = len_of(irInstr_i);
    e_wen  = 1'b0;
    e_rden = 1'b0;
    if (c) begin
      v = '0;
      if (irInstr_i == I_READ) v = 96'(rdData_i);
      else if (irInstr_i == I_IDC) v = 96'(32'h1BEEF001);
      q.delete();
      for (int i = 0; i < L; i++) q.push_back(v[i]);
      e_cnt = 0;
    end else if (s) begin
      void'(q.pop_front());
      q.push_back(t);
      e_cnt = (e_cnt + 1 > L + 1) ? L + 1 : e_cnt + 1;
    end else if (u) begin
      if (e_cnt != L) begin
        e_err = 1'b1;
      end else begin
        v = '0;
        foreach (q[i]) v[i] = q[i];
        case (irInstr_i)
          I_PROG: begin
            e_addr = v[63:0];
            e_data = v[95:64];
            e_wen  = 1'b1;
          end
          I_BURST: begin
            e_addr = e_addr + 64'd4;
            e_data = v[31:0];
            e_wen  = 1'b1;
          end
          I_READ: begin
            e_addr = e_addr + 64'd4;
            e_rden = 1'b1;
          end
          default: begin
          end
        endcase
      end
      e_cnt = 0;
    end
    e_tdo = q[0];
  endtask

  always @(negedge tck_i) begin
    chk("tdo", 96'(tdo_o), 96'(e_tdo));
    chk("wEn", 96'(wEn_o), 96'(e_wen));
    chk("rdEn", 96'(rdEn_o), 96'(e_rden));
    chk("addr", 96'(loadAddr_o), 96'(e_addr));
    chk("data", 96'(loadData_o), 96'(e_data));
    chk("frameErr", 96'(frameErr_o), 96'(e_err));
    if (wEn_o) wen_seen++;
    if (rdEn_o) rden_seen++;
  end

  task automatic step(input logic c, input logic s,
                      input logic u, input logic t);
    captureDR_i = c;
    shiftDR_i   = s;
    updateDR_i  = u;
    tdi_i       = t;
    if (s && !c && nsh < 96) begin
      tdo_bits[nsh] = tdo_o;
      nsh++;
    end
    @(posedge tck_i);
    model_edge(c, s, u, t);
    @(negedge tck_i);
  endtask

  task automatic scan(input logic [3:0] ir, input logic [95:0] val,
                      input int n, input logic upd);
    irInstr_i = ir;
    nsh = 0;
    tdo_bits = '0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b1, 1'b0, (i < 96) ? val[i] : 1'b0);
    if (upd) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, 96'(loadAddr_o), 96'(0));
    chk({tag, "_data"}, 96'(loadData_o), 96'(0));
    chk({tag, "_err"}, 96'(frameErr_o), 96'(0));
    chk({tag, "_tdo"}, 96'(tdo_o), 96'(0));
    chk({tag, "_wen"}, 96'(wEn_o), 96'(0));
  endtask

  initial begin
    trst = 1'b0;
    captureDR_i = 1'b0;
    shiftDR_i = 1'b0;
    updateDR_i = 1'b0;
    tdi_i = 1'b0;
    irInstr_i = I_BYP;
    rdData_i = '0;
    nsh = 0;
    tdo_bits = '0;
    model_reset();
    repeat (2) @(negedge tck_i);
    chk_reset_vals("por");
    trst = 1'b1;

    // T1 full load
    wen_seen = 0;
    scan(I_PROG, {32'h0000_0093, 64'h1}, 96, 1'b1);
    chk("t1_addr", 96'(loadAddr_o), 96'(64'h1));
    chk("t1_data", 96'(loadData_o), 96'(32'h93));
    chk("t1_wen_cnt", 96'(wen_seen), 96'(1));
    chk("t1_err", 96'(frameErr_o), 96'(0));

    // T2 burst
    wen_seen = 0;
    scan(I_BURST, 96'h13, 32, 1'b1);
    chk("t2_addr_a", 96'(loadAddr_o), 96'(64'h5));
    chk("t2_data_a", 96'(loadData_o), 96'(32'h13));
    scan(I_BURST, 96'h6F, 32, 1'b1);
    chk("t2_addr_b", 96'(loadAddr_o), 96'(64'h9));
    chk("t2_data_b", 96'(loadData_o), 96'(32'h6F));
    chk("t2_wen_cnt", 96'(wen_seen), 96'(2));

    // T4 IDCODE and BYPASS
    scan(I_IDC, 96'h0, 32, 1'b1);
    chk("t4_idcode", 96'(tdo_bits[31:0]), 96'(32'h1BEEF001));
    scan(I_BYP, 96'hB2, 8, 1'b0);
    chk("t4_bypass", 96'(tdo_bits[7:0]), 96'(8'h64));

    // T5 readback
    rdData_i = 32'hDEADBEEF;
    wen_seen = 0;
    rden_seen = 0;
    scan(I_READ, 96'h0, 32, 1'b1);
    chk("t5_stream", 96'(tdo_bits[31:0]), 96'(32'hDEADBEEF));
    chk("t5_addr", 96'(loadAddr_o), 96'(64'hD));
    chk("t5_rden_cnt", 96'(rden_seen), 96'(1));
    chk("t5_wen_cnt", 96'(wen_seen), 96'(0));

    // same-edge priority: capture beats shift/update, shift beats update
    irInstr_i = I_PROG;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("prio_err", 96'(frameErr_o), 96'(0));

    // T3 malformed frames
    wen_seen = 0;
    scan(I_PROG, {32'hAA, 64'h40}, 95, 1'b1);
    chk("t3_err95", 96'(frameErr_o), 96'(1));
    chk("t3_addr95", 96'(loadAddr_o), 96'(64'hD));
    chk("t3_data95", 96'(loadData_o), 96'(32'h6F));
    scan(I_PROG, {32'hAA, 64'h40}, 97, 1'b1);
    chk("t3_err97", 96'(frameErr_o), 96'(1));
    chk("t3_addr97", 96'(loadAddr_o), 96'(64'hD));
    chk("t3_wen_cnt", 96'(wen_seen), 96'(0));

    // async reset between edges clears the sticky error
    @(posedge tck_i);
    #2 trst = 1'b0;
    model_reset();
    #1 chk_reset_vals("rst1");
    @(negedge tck_i);
    trst = 1'b1;

    // T6 address wrap, then reset mid-shift
    scan(I_PROG, {32'h1, 64'hFFFF_FFFF_FFFF_FFFC}, 96, 1'b1);
    chk("t6_addr_top", 96'(loadAddr_o), 96'(64'hFFFF_FFFF_FFFF_FFFC));
    scan(I_BURST, 96'h55, 32, 1'b1);
    chk("t6_wrap", 96'(loadAddr_o), 96'(64'h0));
    chk("t6_data", 96'(loadData_o), 96'(32'h55));
    irInstr_i = I_BURST;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    #2 trst = 1'b0;
    model_reset();
    #1 chk_reset_vals("rst2");
    @(negedge tck_i);
    trst = 1'b1;
    scan(I_PROG, {32'hABCD, 64'h1234}, 96, 1'b1);
    chk("t6_addr_after", 96'(loadAddr_o), 96'(64'h1234));
    chk("t6_data_after", 96'(loadData_o), 96'(32'hABCD));
    chk("t6_err_after", 96'(frameErr_o), 96'(0));

    // held update: second update sees a zero count
    irInstr_i = I_BURST;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("held_addr", 96'(loadAddr_o), 96'(64'h1238));
    chk("held_err", 96'(frameErr_o), 96'(1));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
